// File: rtl/fetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_pkg : shared constants and entry types for the fetch front end
// Rev 1.0
// ------------------------------------------------------------------
package fetch_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [DEFAULT_XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic                    epoch;
  } track_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_fifo : two-entry synchronous FIFO with clear, type-parameterized
// Rev 1.0
// ------------------------------------------------------------------
module fetch_fifo import fetch_pkg::*; #(
  parameter type T = logic [31:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_clear,
  input  T           i_wdata,
  output T           o_rdata,
  output logic       o_full,
  output logic       o_empty,
  output logic [1:0] o_count
);

  T           r_mem [2];
  logic       r_rptr;
  logic       r_wptr;
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_push;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A pop frees the slot a simultaneous push takes, even when full.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= 1'b0;
      r_wptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_rptr  <= 1'b0;
      r_wptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= !r_wptr;
      if (w_pop)  r_rptr <= !r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_unit : PC, imem req/gnt/rvalid handshake, epoch-tagged tracking,
//              two-entry instruction buffer and IF/ID register.  Rev 1.0
// ------------------------------------------------------------------
module fetch_unit import fetch_pkg::*; #(
  parameter int               XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  logic [XLEN-1:0] r_pcf;
  logic            r_epoch;
  logic [XLEN-1:0] r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pcplus4_d;
  logic            r_valid_d;

  track_entry_t    w_trk_wdata;
  track_entry_t    w_trk_head;
  logic            w_trk_full;
  logic            w_trk_empty;
  logic [1:0]      w_trk_count;
  fetch_entry_t    w_buf_wdata;
  fetch_entry_t    w_buf_head;
  fetch_entry_t    w_ifid_src;
  logic            w_buf_full;
  logic            w_buf_empty;
  logic [1:0]      w_buf_count;
  logic            w_req;
  logic            w_grant;
  logic            w_resp_ok;
  logic            w_ifid_load;
  logic            w_buf_push;
  logic            w_buf_pop;

  assign w_req   = rst_n && !StallF && !PCSrcE &&
                   (({1'b0, w_trk_count} + {1'b0, w_buf_count}) < 3'd2);
  assign w_grant = w_req && imem_gnt;

  assign w_trk_wdata = '{pc: r_pcf, epoch: r_epoch};
  assign w_resp_ok   = imem_rvalid && !w_trk_empty && !PCSrcE &&
                       (w_trk_head.epoch == r_epoch);
  assign w_buf_wdata = '{pc: w_trk_head.pc, instr: imem_rdata};

  // An empty buffer is fall-through: a fresh response can go straight to decode.
  assign w_ifid_load = !FlushD && !StallD && (!w_buf_empty || w_resp_ok);
  assign w_buf_pop   = w_ifid_load && !w_buf_empty;
  assign w_buf_push  = w_resp_ok && !(w_ifid_load && w_buf_empty);
  assign w_ifid_src  = w_buf_empty ? w_buf_wdata : w_buf_head;

  fetch_fifo #(.T(track_entry_t)) u_trk_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_grant),
    .i_pop   (imem_rvalid),
    .i_clear (1'b0),
    .i_wdata (w_trk_wdata),
    .o_rdata (w_trk_head),
    .o_full  (w_trk_full),
    .o_empty (w_trk_empty),
    .o_count (w_trk_count)
  );

  fetch_fifo #(.T(fetch_entry_t)) u_buf_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_buf_push),
    .i_pop   (w_buf_pop),
    .i_clear (PCSrcE),
    .i_wdata (w_buf_wdata),
    .o_rdata (w_buf_head),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty),
    .o_count (w_buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf   <= RESET_PC;
      r_epoch <= 1'b0;
    end else if (PCSrcE) begin
      r_pcf   <= PCTargetE;
      r_epoch <= !r_epoch;
    end else if (w_grant) begin
      r_pcf   <= r_pcf + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_d   <= 1'b0;
      r_instr_d   <= NOP;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
    end else if (FlushD) begin
      r_valid_d   <= 1'b0;
      r_instr_d   <= NOP;
    end else if (!StallD) begin
      if (w_ifid_load) begin
        r_valid_d   <= 1'b1;
        r_instr_d   <= w_ifid_src.instr;
        r_pc_d      <= w_ifid_src.pc;
        r_pcplus4_d <= w_ifid_src.pc + XLEN'(4);
      end else begin
        r_valid_d   <= 1'b0;
        r_instr_d   <= NOP;
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pcf;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pc_d;
  assign PCPlus4D  = r_pcplus4_d;
  assign ValidD    = r_valid_d;

  a_rvalid_tracked: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> !w_trk_empty)
    else $error("fetch_unit: imem_rvalid with no outstanding request");

  a_trk_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_grant |-> (!w_trk_full || imem_rvalid));

  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_buf_push |-> (!w_buf_full || w_buf_pop));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit : directed + randomized bench against a queue-level fetch model
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic ep; } trk_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  // Model: requests in flight and buffered instructions as plain queues.
  trk_t        m_trk[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  logic        m_ep;
  logic        m_valid;
  logic [31:0] m_instr, m_pcd, m_pcp4;
  int          mem_out;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic model_req();
    return rst_n && !StallF && !PCSrcE && ((m_trk.size() + m_buf.size()) < 2);
  endfunction

  task automatic model_reset();
    m_trk.delete();
    m_buf.delete();
    m_pc    = 32'h0;
    m_ep    = 1'b0;
    m_valid = 1'b0;
    m_instr = NOP_W;
    m_pcd   = 32'h0;
    m_pcp4  = 32'h0;
  endtask

  // Advance the model across the coming rising edge using this cycle's inputs.
  task automatic model_step();
    ent_t avail[$];
    ent_t e;
    trk_t t;
    bit   grant;
    if (imem_rvalid && mem_out > 0) mem_out--;
    if (imem_req && imem_gnt) mem_out++;
    if (!rst_n) begin
      model_reset();
      mem_out = 0;
      return;
    end
    grant = model_req() && imem_gnt;
    avail = m_buf;
    if (imem_rvalid && m_trk.size() > 0) begin
      t = m_trk.pop_front();
      if (t.ep == m_ep && !PCSrcE) begin
        e.pc  = t.pc;
        e.ins = imem_rdata;
        avail.push_back(e);
      end
    end
    if (grant) begin
      t.pc = m_pc;
      t.ep = m_ep;
      m_trk.push_back(t);
      m_pc = m_pc + 32'd4;
    end
    if (FlushD) begin
      m_valid = 1'b0;
      m_instr = NOP_W;
    end else if (!StallD) begin
      if (avail.size() > 0) begin
        e       = avail.pop_front();
        m_valid = 1'b1;
        m_instr = e.ins;
        m_pcd   = e.pc;
        m_pcp4  = e.pc + 32'd4;
      end else begin
        m_valid = 1'b0;
        m_instr = NOP_W;
      end
    end
    if (PCSrcE) begin
      m_buf.delete();
      m_pc = PCTargetE;
      m_ep = !m_ep;
    end else begin
      m_buf = avail;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, model_req()});
      check("imem_addr", imem_addr, m_pc);
      check("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
      check("InstrD", InstrD, m_instr);
      check("PCD", PCD, m_pcd);
      check("PCPlus4D", PCPlus4D, m_pcp4);
    end
  end

  task automatic cyc(input bit sf, input bit sd, input bit fd, input bit ps,
                     input logic [31:0] tgt, input bit g, input int rv_pct);
    @(posedge clk); #1;
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt; imem_gnt = g;
    imem_rvalid = (mem_out > 0) && pct(rv_pct);
    imem_rdata  = $urandom();
    @(negedge clk); #1;
    model_step();
  endtask

  task automatic release_rst();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    rst_n       = 1'b1;
    model_step();
  endtask

  task automatic reset_pulse(input int n, input bit late_rv);
    @(posedge clk); #1;
    rst_n = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0; imem_gnt = 0;
    imem_rvalid = late_rv;
    imem_rdata  = $urandom();
    model_reset();
    mem_out = 0;
    @(negedge clk); #1;
    model_step();
    for (int j = 1; j < n; j++) cyc(0, 0, 0, 0, 32'h0, 0, 0);
    release_rst();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    bit          wrap_seen;
    bit          addr0_seen;
    logic [31:0] prev_addr;

    rst_n = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    mem_out = 0;
    model_reset();
    chk_en = 1'b1;

    cyc(0, 0, 0, 0, 32'h0, 1, 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0);
    check("rst_valid", {31'b0, ValidD}, 32'd0);
    check("rst_instr", InstrD, 32'h0000_0013);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pcp4", PCPlus4D, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    release_rst();

    // Back-to-back grants with one-cycle responses.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 32'h0, 1, 100);
      check("seq_addr", imem_addr, 32'(4 * i));
      if (i >= 2) begin
        check("seq_valid", {31'b0, ValidD}, 32'd1);
        check("seq_pcd", PCD, 32'(4 * (i - 2)));
      end
    end

    // Fill both buffer slots, then stall fetch and decode together.
    cyc(0, 1, 0, 0, 32'h0, 1, 100);
    cyc(0, 1, 0, 0, 32'h0, 0, 100);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 32'h0, 1, 0);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_pcd", PCD, 32'd32);
      check("stall_addr", imem_addr, 32'd44);
    end
    cyc(0, 0, 0, 0, 32'h0, 0, 0);
    check("resume_pcd0", PCD, 32'd32);
    cyc(0, 0, 0, 0, 32'h0, 0, 0);
    check("resume_pcd1", PCD, 32'd36);
    cyc(0, 0, 0, 0, 32'h0, 0, 0);
    check("resume_pcd2", PCD, 32'd40);

    // Two requests in flight at 0x10/0x14, then redirect to 0x100.
    cyc(0, 0, 0, 1, 32'h10, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0);
    check("redir_a_addr", imem_addr, 32'h10);
    cyc(0, 0, 0, 0, 32'h0, 1, 0);
    check("redir_b_addr", imem_addr, 32'h14);
    cyc(0, 0, 0, 1, 32'h100, 1, 0);
    check("redir_req", {31'b0, imem_req}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc(0, 0, 0, 0, 32'h0, 1, 100);
      if (i == 0) check("redir_addr", imem_addr, 32'h100);
      if (ValidD) begin
        check("redir_first_pcd", PCD, 32'h100);
        found = 1'b1;
      end
    end
    check("redir_valid_seen", {31'b0, found}, 32'd1);

    // Flush and stall in the same cycle.
    cyc(0, 1, 1, 0, 32'h0, 1, 100);
    cyc(0, 0, 0, 0, 32'h0, 1, 100);
    check("flush_valid", {31'b0, ValidD}, 32'd0);
    check("flush_instr", InstrD, 32'h0000_0013);

    // PC wrap at the top of the address space.
    cyc(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 100);
    wrap_seen  = 1'b0;
    addr0_seen = 1'b0;
    prev_addr  = 32'hFFFF_FFF8;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 32'h0, 1, 100);
      if (prev_addr == 32'hFFFF_FFFC && imem_addr != prev_addr) begin
        check("wrap_addr", imem_addr, 32'h0);
        addr0_seen = 1'b1;
      end
      prev_addr = imem_addr;
      if (ValidD && PCD == 32'hFFFF_FFFC) begin
        check("wrap_pcp4", PCPlus4D, 32'h0);
        wrap_seen = 1'b1;
      end
    end
    check("wrap_addr_seen", {31'b0, addr0_seen}, 32'd1);
    check("wrap_entry_seen", {31'b0, wrap_seen}, 32'd1);

    // Reset while one response is outstanding; the response lands during reset.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 32'h0, 0, 100);
    cyc(0, 0, 0, 0, 32'h0, 1, 0);
    check("pre_rst_req", {31'b0, imem_req}, 32'd1);
    reset_pulse(2, 1'b1);
    check("mid_rst_valid", {31'b0, ValidD}, 32'd0);
    check("mid_rst_instr", InstrD, 32'h0000_0013);
    check("mid_rst_pcd", PCD, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 1, 100);
    check("restart_addr", imem_addr, 32'h0);
    check("restart_req", {31'b0, imem_req}, 32'd1);

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0)
        reset_pulse(1 + int'($urandom_range(0, 1)), pct(50));
      else
        cyc(pct(15), pct(20), pct(8), pct(6), $urandom() & 32'hFFFF_FFFC, pct(75), 60);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
